// File: rtl/rgb_seq_ctrl.sv
// Table-driven sequencer: replays register writes to rgb_ctrlr over Wishbone and holds each step for a tick count.
// Latency: one FETCH cycle per step plus the bus cycle; backpressure: stalls in WRITE on i_wb_ack, aborts after ACK_TIMEOUT.
module rgb_seq_ctrl #(
    parameter int N_STEPS     = 8,
    parameter int TICK_DIV    = 100000,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic                       i_stop,
    input  logic                       i_loop,
    input  logic [$clog2(N_STEPS):0]   i_len,
    input  logic                       i_tbl_we,
    input  logic [$clog2(N_STEPS)-1:0] i_tbl_addr,
    input  logic [2:0]                 i_tbl_reg,
    input  logic [31:0]                i_tbl_val,
    input  logic [15:0]                i_tbl_hold,
    output logic [5:0]                 o_wb_adr,
    output logic [31:0]                o_wb_dat,
    output logic [3:0]                 o_wb_sel,
    output logic                       o_wb_we,
    output logic                       o_wb_cyc,
    output logic                       o_wb_stb,
    input  logic                       i_wb_ack,
    output logic                       o_busy,
    output logic [$clog2(N_STEPS)-1:0] o_step,
    output logic                       o_done,
    output logic                       o_err
);
    localparam int AW = $clog2(N_STEPS);
    localparam int LW = AW + 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(ACK_TIMEOUT - 1);
    localparam logic [AW-1:0] STEP_MAX = AW'(N_STEPS - 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(N_STEPS);

    typedef struct packed {
        logic [2:0]  reg_idx;
        logic [31:0] val;
        logic [15:0] hold;
    } ent_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_HOLD,
        S_NEXT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    ent_t            r_tbl [N_STEPS];
    ent_t            r_cur;
    ent_t            w_fetch;
    logic [AW-1:0]   r_step;
    logic [PW-1:0]   r_pre;
    logic [15:0]     r_hold_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic            r_stop_lat;
    logic            r_done;
    logic            r_err;
    logic [LW-1:0]   w_step_inc;
    logic            w_last;
    logic            w_pre_wrap;
    logic            w_hold_done;
    logic            w_to_exp;
    logic            w_len_ok;
    logic            w_stop_any;
    logic            w_start_ok;
    logic            w_err_set;
    logic            w_done_set;
    logic            w_wr;

    assign w_fetch     = r_tbl[r_step];
    assign w_step_inc  = {1'b0, r_step} + LW'(1);
    // Last step also at the top index, so a live i_len above N_STEPS can never wrap the counter.
    assign w_last      = (w_step_inc >= i_len) || (r_step == STEP_MAX);
    assign w_pre_wrap  = (r_pre == PRE_MAX);
    assign w_hold_done = (r_cur.hold == 16'd0) ||
                         (w_pre_wrap && (r_hold_cnt == r_cur.hold - 16'd1));
    assign w_to_exp    = (r_to_cnt == TO_MAX);
    assign w_len_ok    = (i_len != '0) && (i_len <= LEN_MAX);
    assign w_stop_any  = i_stop || r_stop_lat;

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_err_set   = 1'b0;
        w_done_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_stop && w_len_ok) begin
                    w_state_nxt = S_FETCH;
                    w_start_ok  = 1'b1;
                end
            end
            S_FETCH: begin
                if (i_stop)
                    w_state_nxt = S_IDLE;
                else if (w_fetch.reg_idx > 3'd5)
                    w_state_nxt = S_HOLD;
                else
                    w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (i_wb_ack) begin
                    w_state_nxt = w_stop_any ? S_IDLE : S_HOLD;
                end else if (w_to_exp) begin
                    w_state_nxt = S_IDLE;
                    w_err_set   = 1'b1;
                end
            end
            S_HOLD: begin
                if (i_stop)
                    w_state_nxt = S_IDLE;
                else if (w_hold_done)
                    w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_last || i_loop) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_done_set  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_STEPS; i++)
                r_tbl[i] <= '0;
        end else if (i_tbl_we) begin
            r_tbl[i_tbl_addr] <= '{reg_idx: i_tbl_reg, val: i_tbl_val, hold: i_tbl_hold};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cur      <= '0;
            r_step     <= '0;
            r_pre      <= '0;
            r_hold_cnt <= '0;
            r_to_cnt   <= '0;
            r_stop_lat <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == S_FETCH)
                r_cur <= w_fetch;
            r_done <= w_done_set;
            if (w_start_ok)
                r_err <= 1'b0;
            else if (w_err_set)
                r_err <= 1'b1;
            if (w_start_ok)
                r_step <= '0;
            else if (r_state == S_NEXT && w_state_nxt == S_FETCH)
                r_step <= w_last ? '0 : r_step + AW'(1);
            // A stop seen mid-bus-cycle waits for ack/timeout so the transfer is never cut short.
            r_stop_lat <= (r_state == S_WRITE) && (r_stop_lat || i_stop);
            r_to_cnt   <= (r_state == S_WRITE) ? r_to_cnt + TW'(1) : '0;
            if (r_state == S_HOLD) begin
                if (w_pre_wrap) begin
                    r_pre      <= '0;
                    r_hold_cnt <= r_hold_cnt + 16'd1;
                end else begin
                    r_pre <= r_pre + PW'(1);
                end
            end else begin
                r_pre      <= '0;
                r_hold_cnt <= '0;
            end
        end
    end

    assign w_wr     = (r_state == S_WRITE);
    assign o_wb_cyc = w_wr;
    assign o_wb_stb = w_wr;
    assign o_wb_we  = w_wr;
    assign o_wb_sel = {4{w_wr}};
    assign o_wb_adr = {r_cur.reg_idx, 2'b00};
    assign o_wb_dat = r_cur.val;
    assign o_busy   = (r_state != S_IDLE);
    assign o_step   = r_step;
    assign o_done   = r_done;
    assign o_err    = r_err;

endmodule
